// File: rtl/thread_sched_pkg.sv
// Shared types and constants for the barrel-thread fetch scheduler.
package thread_sched_pkg;

  localparam int XLEN         = 32;
  localparam int THREAD_WIDTH = 2;
  localparam int NUM_THREADS  = 2 ** THREAD_WIDTH;

  typedef logic [THREAD_WIDTH-1:0] tid_t;
  typedef logic [XLEN-1:0]         xlen_t;

  // One fetch issue towards the instr stage.
  typedef struct packed {
    xlen_t pc;
    tid_t  thread_id;
  } sched_issue_t;

  // One resolution coming back from execute.
  typedef struct packed {
    tid_t  thread_id;
    logic  redirect;
    xlen_t pc;
  } sched_resolve_t;

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } sched_state_e;

  // Redirect targets are forced to word alignment (no compressed instructions).
  function automatic xlen_t align_pc(input xlen_t pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester strictly after ptr,
// wrapping, so ptr itself has the lowest priority. N must be a power of two >= 2.
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx
);

  logic [W-1:0] cand;

  // Scan from the farthest offset down so the nearest requester after ptr wins last.
  always_comb begin
    // NOTE: every output gets a default before any branch, otherwise a latch is inferred.
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = N; i >= 1; i--) begin
      cand = ptr + W'(i);
      if (req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/thread_sched.sv
// Barrel-thread fetch scheduler: one PC per hardware thread, round-robin issue over
// enabled, idle threads, at most one instruction in flight per thread.
module thread_sched
  import thread_sched_pkg::*;
#(
  parameter xlen_t RESET_PC = '0,
  parameter xlen_t PC_INC   = xlen_t'(4)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_i,
  input  logic [NUM_THREADS-1:0]  thread_en_i,
  input  logic                    fetch_ready_i,
  output logic                    pc_valid_o,
  output logic [XLEN-1:0]         pc_pc_o,
  output logic [THREAD_WIDTH-1:0] pc_thread_id_o,
  input  logic                    resolve_valid_i,
  input  logic [THREAD_WIDTH-1:0] resolve_thread_id_i,
  input  logic                    resolve_redirect_i,
  input  logic [XLEN-1:0]         resolve_pc_i,
  output logic [NUM_THREADS-1:0]  inflight_o,
  output logic                    err_o
);

  sched_state_e           state_q, state_d;
  xlen_t                  pc_q [NUM_THREADS];
  logic [NUM_THREADS-1:0] inflight_q;
  tid_t                   rr_ptr_q;
  sched_issue_t           issue_q, issue_d;
  logic                   valid_q, valid_d;
  logic                   issue_load;
  logic                   err_q;

  logic [NUM_THREADS-1:0] eligible, arb_req;
  tid_t                   arb_ptr, gnt_idx;
  logic                   gnt_valid;
  logic                   accept;
  logic                   res_legal;
  sched_resolve_t         res;

  assign res = '{thread_id: resolve_thread_id_i,
                 redirect:  resolve_redirect_i,
                 pc:        resolve_pc_i};

  // Eligibility comes from registered state only: a resolved thread competes next cycle.
  assign eligible  = thread_en_i & ~inflight_q;
  assign accept    = (state_q == S_HOLD) & fetch_ready_i & ~stall_i;
  assign res_legal = resolve_valid_i & inflight_q[res.thread_id];

  // While an issue is held its thread is not yet marked in flight, so mask it out and
  // arbitrate from it, as if the pointer had already advanced to the accepted thread.
  always_comb begin
    arb_req = eligible;
    arb_ptr = rr_ptr_q;
    if (state_q == S_HOLD) begin
      arb_req = eligible & ~(NUM_THREADS'(1) << issue_q.thread_id);
      arb_ptr = issue_q.thread_id;
    end
  end

  rr_arbiter #(.N(NUM_THREADS)) u_arb (
    .req       (arb_req),
    .ptr       (arb_ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next state and issue-register load: select in IDLE, or right after an accept in HOLD.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    issue_load = 1'b0;
    issue_d    = '{pc: pc_q[gnt_idx], thread_id: gnt_idx};
    unique case (state_q)
      S_IDLE: begin
        if (!stall_i && gnt_valid) begin
          issue_load = 1'b1;
          valid_d    = 1'b1;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (accept) begin
          if (gnt_valid) begin
            issue_load = 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Issue output registers; contents stay frozen until the next selection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      issue_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (issue_load) issue_q <= issue_d;
    end
  end

  // In-flight tracking, rr pointer and sticky error. The accept assignment comes last so
  // it wins the in-flight bit on an (illegal) same-thread resolve/accept collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= '0;
      rr_ptr_q   <= tid_t'(NUM_THREADS - 1);
      err_q      <= 1'b0;
    end else begin
      if (resolve_valid_i) begin
        if (res_legal) inflight_q[res.thread_id] <= 1'b0;
        else           err_q                     <= 1'b1;
      end
      if (accept) begin
        inflight_q[issue_q.thread_id] <= 1'b1;
        rr_ptr_q                      <= issue_q.thread_id;
      end
    end
  end

  // PC file: one write port driven by legal resolves, read through the grant index.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: this array is reset on purpose; every thread must start fetching at RESET_PC.
    if (!rst) begin
      for (int t = 0; t < NUM_THREADS; t++) pc_q[t] <= RESET_PC;
    end else if (res_legal) begin
      pc_q[res.thread_id] <= res.redirect ? align_pc(res.pc)
                                          : pc_q[res.thread_id] + PC_INC;
    end
  end

  assign pc_valid_o     = valid_q;
  assign pc_pc_o        = issue_q.pc;
  assign pc_thread_id_o = issue_q.thread_id;
  assign inflight_o     = inflight_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_thread_sched.sv
// Scoreboard bench for thread_sched: directed stimulus pushes expected issues, a monitor
// pops and compares them on every accepted handshake.
module tb_thread_sched;
  import thread_sched_pkg::*;

  logic        clk                 = 1'b0;
  logic        rst                 = 1'b0;
  logic        stall_i             = 1'b0;
  logic [3:0]  thread_en_i         = 4'hF;
  logic        fetch_ready_i       = 1'b1;
  logic        pc_valid_o;
  logic [31:0] pc_pc_o;
  logic [1:0]  pc_thread_id_o;
  logic        resolve_valid_i     = 1'b0;
  logic [1:0]  resolve_thread_id_i = 2'd0;
  logic        resolve_redirect_i  = 1'b0;
  logic [31:0] resolve_pc_i        = 32'd0;
  logic [3:0]  inflight_o;
  logic        err_o;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [33:0] exp_q[$];

  always #5 clk = ~clk;

  thread_sched dut (
    .clk                 (clk),
    .rst                 (rst),
    .stall_i             (stall_i),
    .thread_en_i         (thread_en_i),
    .fetch_ready_i       (fetch_ready_i),
    .pc_valid_o          (pc_valid_o),
    .pc_pc_o             (pc_pc_o),
    .pc_thread_id_o      (pc_thread_id_o),
    .resolve_valid_i     (resolve_valid_i),
    .resolve_thread_id_i (resolve_thread_id_i),
    .resolve_redirect_i  (resolve_redirect_i),
    .resolve_pc_i        (resolve_pc_i),
    .inflight_o          (inflight_o),
    .err_o               (err_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] tid, input logic [31:0] pc);
    exp_q.push_back({tid, pc});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic resolve(input logic [1:0] tid, input logic redir, input logic [31:0] pc);
    resolve_valid_i     = 1'b1;
    resolve_thread_id_i = tid;
    resolve_redirect_i  = redir;
    resolve_pc_i        = pc;
    tick(1);
    resolve_valid_i    = 1'b0;
    resolve_redirect_i = 1'b0;
  endtask

  // Wait (bounded) until every expected issue was seen, then let the pipe settle.
  task automatic drain(input string name);
    int budget = 50;
    while (exp_q.size() != 0 && budget > 0) begin
      tick(1);
      budget--;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    tick(2);
  endtask

  // Monitor: every accepted issue must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && pc_valid_o && fetch_ready_i && !stall_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_issue: got t%0d pc 0x%0h expected none",
                 pc_thread_id_o, pc_pc_o);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("issue_tid", 32'(pc_thread_id_o), 32'(e[33:32]));
        check("issue_pc", pc_pc_o, e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, observed with no clock edge yet.
    #2;
    check("rst_valid", 32'(pc_valid_o), 32'd0);
    check("rst_pc", pc_pc_o, 32'd0);
    check("rst_tid", 32'(pc_thread_id_o), 32'd0);
    check("rst_inflight", 32'(inflight_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);

    // 1: all four threads issue once at RESET_PC, then the block idles.
    push(2'd0, 32'h0); push(2'd1, 32'h0); push(2'd2, 32'h0); push(2'd3, 32'h0);
    #20 rst = 1'b1;
    tick(1);
    drain("t1_drain");
    check("t1_idle_valid", 32'(pc_valid_o), 32'd0);
    check("t1_inflight", 32'(inflight_o), 32'hF);

    // 2: sequential resolves advance by 4.
    push(2'd1, 32'h4);
    resolve(2'd1, 1'b0, 32'h0);
    drain("t2a_drain");
    push(2'd1, 32'h8);
    resolve(2'd1, 1'b0, 32'h0);
    drain("t2b_drain");

    // 3: redirect aligns the target; sequential increment wraps at 2^32.
    push(2'd2, 32'h100);
    resolve(2'd2, 1'b1, 32'h103);
    drain("t3a_drain");
    push(2'd3, 32'hFFFF_FFFC);
    resolve(2'd3, 1'b1, 32'hFFFF_FFFC);
    drain("t3b_drain");
    push(2'd3, 32'h0);
    resolve(2'd3, 1'b0, 32'h0);
    drain("t3c_drain");
    check("t3_inflight", 32'(inflight_o), 32'hF);

    // 4: held issue under backpressure, then under stall with a resolve processed.
    fetch_ready_i = 1'b0;
    push(2'd0, 32'h4);
    resolve(2'd0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("t4_hold_valid", 32'(pc_valid_o), 32'd1);
      check("t4_hold_pc", pc_pc_o, 32'h4);
      check("t4_hold_tid", 32'(pc_thread_id_o), 32'd0);
    end
    stall_i       = 1'b1;
    fetch_ready_i = 1'b1;
    check("t4_inflight_pre", 32'(inflight_o), 32'hE);
    push(2'd1, 32'hC);
    resolve(2'd1, 1'b0, 32'h0);
    check("t4_inflight_stall", 32'(inflight_o), 32'hC);
    tick(1);
    check("t4_stall_valid", 32'(pc_valid_o), 32'd1);
    check("t4_stall_pc", pc_pc_o, 32'h4);
    stall_i = 1'b0;
    drain("t4_drain");
    check("t4_inflight_post", 32'(inflight_o), 32'hF);

    // 5: spurious resolve flags a sticky error and leaves the PC alone; then t0/t2 only.
    thread_en_i = 4'b0000;
    resolve(2'd0, 1'b0, 32'h0);
    check("t5_err_clean", 32'(err_o), 32'd0);
    check("t5_inflight_a", 32'(inflight_o), 32'hE);
    resolve(2'd0, 1'b0, 32'h0);
    check("t5_err_set", 32'(err_o), 32'd1);
    check("t5_inflight_b", 32'(inflight_o), 32'hE);
    tick(3);
    check("t5_err_sticky", 32'(err_o), 32'd1);
    push(2'd0, 32'h8);
    thread_en_i = 4'b0101;
    drain("t5a_drain");
    resolve(2'd1, 1'b0, 32'h0);
    check("t5_inflight_c", 32'(inflight_o), 32'hD);
    push(2'd2, 32'h104);
    resolve(2'd2, 1'b0, 32'h0);
    drain("t5b_drain");
    push(2'd0, 32'hC);
    resolve(2'd0, 1'b0, 32'h0);
    drain("t5c_drain");
    fetch_ready_i = 1'b0;
    push(2'd2, 32'h108);
    push(2'd0, 32'h10);
    resolve(2'd2, 1'b0, 32'h0);
    resolve(2'd0, 1'b0, 32'h0);
    tick(2);
    fetch_ready_i = 1'b1;
    drain("t5d_drain");
    check("t5_err_end", 32'(err_o), 32'd1);

    // 6: asynchronous reset in the middle of a held issue, then a clean restart.
    fetch_ready_i = 1'b0;
    resolve(2'd2, 1'b0, 32'h0);
    tick(2);
    check("t6_held_valid", 32'(pc_valid_o), 32'd1);
    check("t6_held_tid", 32'(pc_thread_id_o), 32'd2);
    #3 rst = 1'b0;
    #1;
    check("t6_rst_valid", 32'(pc_valid_o), 32'd0);
    check("t6_rst_pc", pc_pc_o, 32'd0);
    check("t6_rst_tid", 32'(pc_thread_id_o), 32'd0);
    check("t6_rst_inflight", 32'(inflight_o), 32'd0);
    check("t6_rst_err", 32'(err_o), 32'd0);
    thread_en_i   = 4'hF;
    fetch_ready_i = 1'b1;
    push(2'd0, 32'h0); push(2'd1, 32'h0); push(2'd2, 32'h0); push(2'd3, 32'h0);
    #7 rst = 1'b1;
    tick(1);
    drain("t6_drain");
    check("t6_inflight", 32'(inflight_o), 32'hF);
    check("t6_valid_end", 32'(pc_valid_o), 32'd0);
    check("t6_err_end", 32'(err_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
